spi_peek_regbank: RTL and testbench
===================================

// Module: spi_peek_regbank
// PURPOSE
//  Command sequencer for the 64-bit SPI peek shift register.
//  - Watches the raw active-low select line and waits for each SPI frame to end.
//  - Decodes the latched frame as opcode/address/data and executes it.
//  - Execution is a write to a bank of 32-bit control registers, or a read of a
//    control or status register.
//  - Drives the peek preload word, so the reply is shifted out on the next frame.
//  - Sits between the peek shifter and the rest of the FPGA.
// PARAMETERS
//  NREGS   8  number of 32-bit read/write control registers (1..16)
//  NSTAT   8  number of 32-bit read-only status inputs (1..16)
//  SETTLE  2  clk cycles to wait after frame end before sampling frame_in (>=2)
// PORTS
//  clk        in   1          system clock, all logic on rising edge
//  rst_n      in   1          asynchronous active-low reset
//  ucSEL_     in   1          raw SPI select, active low, asynchronous to clk
//  frame_in   in   64         frame latched by peek shifter at end of select
//  reply_out  out  64         preload word for peek shifter (its data_in)
//  ctrl_regs  out  32*NREGS   control registers, reg k at [32k+31:32k]
//  wr_stb     out  NREGS      one-cycle pulse on the cycle reg k is written
//  stat_in    in   32*NSTAT   status words, word k at [32k+31:32k]
//  busy       out  1          high from frame end until the reply is loaded
// BEHAVIOUR
//  Sync and edge detect:
//  - ucSEL_ passes through a 3-flop synchronizer (reset value 3'b111).
//  - start = synced falling edge; end = synced rising edge.
//  Frame layout:
//  - op=[63:56], addr=[55:48], [47:32] ignored, wdata=[31:0].
//  Opcodes:
//  - 0x00 NOP: reply rdata = 0.
//  - 0x01 WRITE: ctrl[addr] <= wdata; rdata = new value.
//  - 0x02 RDCTRL: rdata = ctrl[addr].
//  - 0x03 RDSTAT: rdata = stat[addr], sampled in the EXEC cycle.
//  - Any other opcode sets err_op; no write occurs; rdata = 0.
//  - Address >= NREGS (WRITE/RDCTRL) or >= NSTAT (RDSTAT) sets err_addr;
//    no write occurs; rdata = 0.
//  Reply layout:
//  - [63:56] = 8'hA5.
//  - [55:48] = {err_op, err_addr, overrun, 5'b0}.
//  - [47:40] = echoed addr; [39:32] = frame count mod 256, counted after increment.
//  - [31:0] = rdata.
//  FSM (one-hot or binary, implementer's choice):
//  - IDLE: waits for start; goes to XFER.
//  - XFER: select active; end -> SETTLE state, busy=1.
//  - SETTLE: counts SETTLE cycles, then DECODE.
//  - DECODE: captures op/addr/wdata from frame_in and checks errors; next EXEC.
//  - EXEC: performs the write (wr_stb pulses here for exactly 1 cycle, and
//    ctrl_regs updates on the same edge) or the read; next RESP.
//  - RESP: loads reply_out, increments frame count, clears busy; next IDLE.
//  - Latency: reply_out is valid SETTLE+3 clk cycles after the synced end edge.
//  reply_out is held constant outside RESP, so it is stable at the next start.
//  Overrun:
//  - A start seen in SETTLE/DECODE/EXEC/RESP sets overrun in that frame's reply.
//  - Processing still completes; after RESP the FSM goes to XFER instead of IDLE.
//  - reply_out for the overlapping frame is whatever the shifter loaded.
//  A start and end in the same cycle cannot occur (both come from one synced
//  line).
//  Reset values:
//  - FSM=IDLE, ctrl_regs=0, wr_stb=0, busy=0, frame count=0.
//  - reply_out = {8'hA5, 56'h0}.
//  - Reset mid-frame discards that frame with no write; the next full frame is
//    decoded normally.
//  Frame count wraps 255 -> 0 silently.
// TESTING
//  1. Reset, no SPI -> reply_out=64'hA500_0000_0000_0000, ctrl_regs=0, busy=0.
//  2. Frame 0x01_03_0000_DEADBEEF -> wr_stb[3] single pulse, ctrl_regs[3]=DEADBEEF,
//     reply_out=0xA5_00_03_01_DEADBEEF.
//  3. Then frame 0x03_02_0000_00000000 with stat_in[2]=0x12345678 ->
//     reply_out=0xA5_00_02_02_12345678; no wr_stb.
//  4. Frame 0x01_09_... (NREGS=8) -> no write, reply flags=0x40, rdata=0;
//     frame op=0x7F -> flags=0x80.
//  5. Reassert ucSEL_ low 1 clk after end -> overrun flag 0x20 in reply, FSM in
//     XFER, next frame decoded correctly.
//  6. rst_n low during XFER, then 256 WRITE frames -> no spurious write; count
//     field wraps to 0x00 on frame 256.

Source files
------------

// File: rtl/spi_peek_regbank.sv
// spi_peek_regbank
//   Command sequencer behind the 64-bit SPI peek shift register. It waits for
//   each SPI frame to end, decodes the latched frame (op/addr/wdata), writes a
//   control register or reads a control/status register, and presents a reply
//   word that the peek shifter loads and shifts out on the following frame.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   ucSEL_     raw SPI select (active low, asynchronous to clk)
//   frame_in   64-bit frame latched by the shifter at the end of select
//   reply_out  64-bit preload word for the shifter
//   ctrl_regs  NREGS x 32-bit control registers, reg k at [32k+31:32k]
//   wr_stb     per-register one-cycle write strobe
//   stat_in    NSTAT x 32-bit status words, word k at [32k+31:32k]
//   busy       high from frame end until the reply is loaded
module spi_peek_regbank #(
   parameter int NREGS  = 8,
   parameter int NSTAT  = 8,
   parameter int SETTLE = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ucSEL_,
   input  logic [63:0]           frame_in,
   output logic [63:0]           reply_out,
   output logic [32*NREGS-1:0]   ctrl_regs,
   output logic [NREGS-1:0]      wr_stb,
   input  logic [32*NSTAT-1:0]   stat_in,
   output logic                  busy
);

   localparam int CW  = $clog2(SETTLE + 1);
   localparam int RAW = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam int SAW = (NSTAT > 1) ? $clog2(NSTAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_XFER, S_SETTLE, S_DECODE, S_EXEC, S_RESP
   } state_t;

   state_t          state_q;
   logic [2:0]      sync_q;
   logic [2:0]      vld_q;
   logic            armed_q;
   logic [CW-1:0]   cnt_q;
   logic [7:0]      op_q;
   logic [7:0]      addr_q;
   logic [31:0]     wdata_q;
   logic            err_op_q;
   logic            err_addr_q;
   logic            ovr_q;
   logic            pend_q;
   logic [31:0]     rdata_q;
   logic [7:0]      fcnt_q;
   logic [63:0]     reply_q;
   logic            busy_q;

   logic [31:0]     ctrl_w [NREGS];
   logic [31:0]     stat_w [NSTAT];

   // Edge detection. vld_q marks which synchronizer stages hold real samples
   // rather than reset fill; a start is only accepted once select has been
   // seen genuinely high, so a frame already in progress when reset is
   // released is ignored instead of being decoded half-shifted.
   logic sel_arm, start_w, end_w, in_proc;
   assign sel_arm = armed_q | (vld_q[2] & sync_q[2]);
   assign start_w = sel_arm & sync_q[2] & ~sync_q[1];
   assign end_w   = sync_q[1] & ~sync_q[2];
   assign in_proc = (state_q == S_SETTLE) || (state_q == S_DECODE) ||
                    (state_q == S_EXEC)   || (state_q == S_RESP);

   // Frame decode, evaluated directly on frame_in during DECODE.
   logic [7:0]  dec_op, dec_addr;
   logic [31:0] dec_wdata;
   logic        dec_err_op, dec_err_addr, wr_go;
   logic        unused_bits;
   assign dec_op      = frame_in[63:56];
   assign dec_addr    = frame_in[55:48];
   assign dec_wdata   = frame_in[31:0];
   assign unused_bits = ^frame_in[47:32];
   assign dec_err_op  = (dec_op > 8'h03);
   assign dec_err_addr = ((dec_op == 8'h01) || (dec_op == 8'h02)) ? (dec_addr >= 8'(NREGS)) :
                         (dec_op == 8'h03) ? (dec_addr >= 8'(NSTAT)) : 1'b0;
   assign wr_go = (state_q == S_DECODE) && (dec_op == 8'h01) && !dec_err_addr;

   // Write happens on the DECODE->EXEC edge so that the strobe is high during
   // EXEC and the register shows its new value in that same cycle.
   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_ctrl
         logic [31:0] reg_q;
         logic        stb_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               reg_q <= '0;
               stb_q <= 1'b0;
            end else begin
               stb_q <= wr_go && (dec_addr == 8'(gi));
               if (wr_go && (dec_addr == 8'(gi)))
                  reg_q <= dec_wdata;
            end
         end
         assign ctrl_w[gi]              = reg_q;
         assign ctrl_regs[32*gi +: 32]  = reg_q;
         assign wr_stb[gi]              = stb_q;
      end
      for (gi = 0; gi < NSTAT; gi++) begin : g_stat
         assign stat_w[gi] = stat_in[32*gi +: 32];
      end
   endgenerate

   // Read data, sampled at the end of EXEC.
   logic [31:0] rd_d;
   always_comb begin
      rd_d = '0;
      if (!err_op_q && !err_addr_q) begin
         case (op_q)
            8'h01:   rd_d = wdata_q;
            8'h02:   rd_d = ctrl_w[addr_q[RAW-1:0]];
            8'h03:   rd_d = stat_w[addr_q[SAW-1:0]];
            default: rd_d = '0;
         endcase
      end
   end

   logic [7:0] fcnt_d;
   logic       ovr_now, pend_now;
   assign fcnt_d   = fcnt_q + 8'd1;
   assign ovr_now  = ovr_q | start_w;
   // An end that arrives after an overlapping start is the end of the next
   // frame; remember it so that frame is still processed.
   assign pend_now = pend_q | (end_w & ovr_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= 3'b111;
         vld_q      <= 3'b000;
         armed_q    <= 1'b0;
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_op_q   <= 1'b0;
         err_addr_q <= 1'b0;
         ovr_q      <= 1'b0;
         pend_q     <= 1'b0;
         rdata_q    <= '0;
         fcnt_q     <= '0;
         reply_q    <= {8'hA5, 56'h0};
         busy_q     <= 1'b0;
      end else begin
         sync_q  <= {sync_q[1:0], ucSEL_};
         vld_q   <= {vld_q[1:0], 1'b1};
         armed_q <= sel_arm;
         if (in_proc) begin
            if (start_w)         ovr_q  <= 1'b1;
            if (end_w && ovr_q)  pend_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (start_w) state_q <= S_XFER;
            end
            S_XFER: begin
               if (end_w) begin
                  state_q <= S_SETTLE;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  ovr_q   <= 1'b0;
                  pend_q  <= 1'b0;
               end
            end
            S_SETTLE: begin
               if (cnt_q == CW'(SETTLE - 1)) state_q <= S_DECODE;
               else                          cnt_q   <= cnt_q + 1'b1;
            end
            S_DECODE: begin
               op_q       <= dec_op;
               addr_q     <= dec_addr;
               wdata_q    <= dec_wdata;
               err_op_q   <= dec_err_op;
               err_addr_q <= dec_err_addr;
               state_q    <= S_EXEC;
            end
            S_EXEC: begin
               rdata_q <= rd_d;
               state_q <= S_RESP;
            end
            S_RESP: begin
               reply_q <= {8'hA5, err_op_q, err_addr_q, ovr_now, 5'b0,
                           addr_q, fcnt_d, rdata_q};
               fcnt_q  <= fcnt_d;
               ovr_q   <= 1'b0;
               pend_q  <= 1'b0;
               if (pend_now) begin
                  state_q <= S_SETTLE;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ovr_now ? S_XFER : S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign reply_out = reply_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_spi_peek_regbank.sv
module tb_spi_peek_regbank;
   localparam int NREGS = 8, NSTAT = 8, SETTLE = 2;

   logic          clk = 1'b0;
   logic          rst_n, ucSEL_, busy;
   logic [63:0]   frame_in, reply_out;
   logic [255:0]  ctrl_regs, stat_in;
   logic [7:0]    wr_stb;

   always #5 clk = ~clk;

   spi_peek_regbank #(.NREGS(NREGS), .NSTAT(NSTAT), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .ucSEL_(ucSEL_), .frame_in(frame_in),
      .reply_out(reply_out), .ctrl_regs(ctrl_regs), .wr_stb(wr_stb),
      .stat_in(stat_in), .busy(busy)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_ctrl [8];
   logic [31:0] st [8];
   logic [7:0]  m_cnt;
   logic [63:0] m_reply;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_wide(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] model_ctrl();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[32*k +: 32] = m_ctrl[k];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic load_stat(input bit randomize_all);
      for (int k = 0; k < 8; k++) begin
         if (randomize_all) st[k] = $urandom;
         stat_in[32*k +: 32] = st[k];
      end
   endtask

   task automatic begin_sel();
      ucSEL_ = 1'b0;
      repeat ($urandom_range(4, 8)) tick();
   endtask

   // Ends the current frame with 'frame' latched, optionally re-asserting
   // select one clock later, and checks the result against the model.
   task automatic end_frame(input logic [63:0] frame, input bit reassert,
                            input bit exp_ovr, input string tag);
      logic [7:0]  op, addr, exp_stb, stb_seen;
      logic [31:0] wd, rd;
      logic [63:0] exp;
      bit          eop, eaddr, busy_seen, held, done;
      int          stb_cycles;
      op   = frame[63:56];
      addr = frame[55:48];
      wd   = frame[31:0];
      eop  = (op > 8'd3);
      eaddr = (op == 8'd3) ? (addr >= 8'(NSTAT)) :
              (op == 8'd1 || op == 8'd2) ? (addr >= 8'(NREGS)) : 1'b0;
      rd = 32'h0;
      exp_stb = 8'h0;
      if (!eop && !eaddr) begin
         case (op)
            8'd1: begin m_ctrl[addr[2:0]] = wd; rd = wd; exp_stb = 8'h1 << addr[2:0]; end
            8'd2: rd = m_ctrl[addr[2:0]];
            8'd3: rd = st[addr[2:0]];
            default: rd = 32'h0;
         endcase
      end
      m_cnt = m_cnt + 8'd1;
      exp = {8'hA5, eop, eaddr, exp_ovr, 5'b0, addr, m_cnt, rd};

      frame_in = frame;
      ucSEL_   = 1'b1;
      stb_cycles = 0; stb_seen = 8'h0; busy_seen = 0; held = 1; done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         tick();
         if (c == 0 && reassert) ucSEL_ = 1'b0;
         if (wr_stb != 8'h0) begin stb_cycles++; stb_seen |= wr_stb; end
         if (busy) begin
            busy_seen = 1;
            if (reply_out !== m_reply) held = 0;
         end else if (busy_seen) done = 1;
      end
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_reply"}, reply_out, exp);
      chk({tag, "_stbcyc"}, 64'(stb_cycles), (exp_stb != 0) ? 64'd1 : 64'd0);
      chk({tag, "_stbval"}, 64'(stb_seen), 64'(exp_stb));
      chk({tag, "_held"}, 64'(held), 64'd1);
      chk_wide({tag, "_ctrl"}, ctrl_regs, model_ctrl());
      $display("frame %s: frame=%h reply=%h expected=%h", tag, frame, reply_out, exp);
      m_reply = exp;
   endtask

   initial begin
      logic [7:0] op, addr;
      bit         ra, stb_any, busy_any;
      rst_n = 1'b0; ucSEL_ = 1'b1; frame_in = 64'h0; stat_in = '0;
      for (int k = 0; k < 8; k++) m_ctrl[k] = 32'h0;
      m_cnt = 8'h0;
      m_reply = {8'hA5, 56'h0};
      load_stat(1);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (6) tick();

      // 1: reset state
      chk("rst_reply", reply_out, 64'hA500_0000_0000_0000);
      chk_wide("rst_ctrl", ctrl_regs, 256'h0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_stb", 64'(wr_stb), 64'd0);

      // 2: write
      begin_sel();
      end_frame(64'h01_03_0000_DEADBEEF, 0, 0, "write3");
      chk("write3_const", reply_out, 64'hA5_00_03_01_DEADBEEF);

      // 3: status read
      st[2] = 32'h12345678; load_stat(0);
      begin_sel();
      end_frame(64'h03_02_0000_00000000, 0, 0, "rdstat2");
      chk("rdstat2_const", reply_out, 64'hA5_00_02_02_12345678);

      // 4: address and opcode errors
      begin_sel();
      end_frame(64'h01_09_0000_11112222, 0, 0, "badaddr");
      chk("badaddr_flags", 64'(reply_out[55:48]), 64'h40);
      begin_sel();
      end_frame(64'h7F_00_0000_33334444, 0, 0, "badop");
      chk("badop_flags", 64'(reply_out[55:48]), 64'h80);

      // 5: overrun, then a normal frame from XFER
      begin_sel();
      end_frame(64'h02_03_0000_00000000, 1, 1, "overrun");
      chk("overrun_flags", 64'(reply_out[55:48]), 64'h20);
      repeat (4) tick();
      end_frame(64'h02_03_0000_00000000, 0, 0, "after_ovr");
      chk("after_ovr_const", reply_out, 64'hA5_00_03_06_DEADBEEF);

      // randomized frames
      for (int i = 0; i < 40; i++) begin
         load_stat(1);
         case ($urandom_range(0, 9))
            0: op = 8'h00;
            1, 2: op = 8'h02;
            3, 4: op = 8'h03;
            5, 6, 7: op = 8'h01;
            default: op = 8'($urandom_range(4, 255));
         endcase
         addr = 8'($urandom_range(0, 11));
         ra = ($urandom_range(0, 4) == 0);
         begin_sel();
         end_frame({op, addr, 16'($urandom), 32'($urandom)}, ra, ra, "rand");
      end

      // 6: reset in the middle of a frame, then 256 writes to check wrap
      ucSEL_ = 1'b0;
      repeat (6) tick();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      frame_in = 64'h01_01_0000_CAFEF00D;
      repeat (5) tick();
      ucSEL_ = 1'b1;
      stb_any = 0; busy_any = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (wr_stb != 8'h0) stb_any = 1;
         if (busy) busy_any = 1;
      end
      chk("midrst_stb", 64'(stb_any), 64'd0);
      chk("midrst_busy", 64'(busy_any), 64'd0);
      chk("midrst_reply", reply_out, 64'hA500_0000_0000_0000);
      chk_wide("midrst_ctrl", ctrl_regs, 256'h0);
      for (int k = 0; k < 8; k++) m_ctrl[k] = 32'h0;
      m_cnt = 8'h0;
      m_reply = {8'hA5, 56'h0};
      for (int i = 0; i < 256; i++) begin
         begin_sel();
         end_frame({8'h01, 8'($urandom_range(0, 7)), 16'h0, 32'($urandom)}, 0, 0, "wrap");
      end
      chk("wrap_count", 64'(reply_out[39:32]), 64'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
